// File: rtl/inning_counter.sv
`default_nettype none
// ============================================================================
//  Module      : inning_counter
//  Description : Half-inning / inning tracker for the scoreboard. Consumes the
//                three-out change pulse, advances top/bottom of each inning,
//                applies the end-of-game rules (home lead after the top of the
//                last inning, walk-off, decisive bottom half, draw at the
//                extra-inning cap) and drives the half LEDs, the one-digit
//                seven-segment inning display, the tens LED and game status.
//  Revision    : 1.0 - initial release
// ============================================================================
module inning_counter #(
  parameter int LAST_INNING = 9,
  parameter int MAX_INNING  = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       change_pulse,
  input  logic       home_lead,
  input  logic       tie,
  input  logic       new_game,
  output logic       top_led,
  output logic       bottom_led,
  output logic       game_over,
  output logic [3:0] inning,
  output logic [6:0] inning_seg,
  output logic       tens_led,
  output logic       adv_pulse,
  output logic       end_pulse
);

  // Inning thresholds narrowed to the width of the inning register.
  localparam logic [3:0] c_LAST_INNING = 4'(LAST_INNING);
  localparam logic [3:0] c_MAX_INNING  = 4'(MAX_INNING);
  localparam logic [3:0] c_FIRST       = 4'd1;
  localparam logic [3:0] c_TEN         = 4'd10;

  // Encoding 2'b11 is unused and recovers to TOP of the first inning.
  typedef enum logic [1:0] {
    S_TOP       = 2'b00,
    S_BOTTOM    = 2'b01,
    S_GAME_OVER = 2'b10
  } state_t;

  state_t     r_state;
  logic [3:0] r_inning;

  state_t     w_state_nxt;
  logic [3:0] w_inning_nxt;
  logic       w_adv_nxt;
  logic       w_end_nxt;
  logic       w_late;        // current inning is regulation-final or later
  logic       w_at_cap;      // no further extra inning is allowed
  logic [3:0] w_ones_nxt;
  logic [6:0] w_seg_nxt;

  // Active-high segment pattern (bit6..bit0 = a..g) for a decimal digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  assign w_late   = (r_inning >= c_LAST_INNING);
  assign w_at_cap = (r_inning >= c_MAX_INNING);

  // Next half-inning state, inning number and event pulses.
  always_comb begin
    w_state_nxt  = r_state;
    w_inning_nxt = r_inning;
    w_adv_nxt    = 1'b0;
    w_end_nxt    = 1'b0;

    if (new_game) begin
      // Restart wins over any pending out pulse or walk-off, silently.
      w_state_nxt  = S_TOP;
      w_inning_nxt = c_FIRST;
    end else begin
      case (r_state)
        S_TOP: begin
          if (change_pulse) begin
            if (w_late && home_lead) begin
              // Home team already ahead: bottom half is not played.
              w_state_nxt = S_GAME_OVER;
              w_end_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_BOTTOM;
              w_adv_nxt   = 1'b1;
            end
          end
        end

        S_BOTTOM: begin
          if (w_late && home_lead) begin
            // Walk-off: ends the game with or without the out pulse.
            w_state_nxt = S_GAME_OVER;
            w_end_nxt   = 1'b1;
          end else if (change_pulse) begin
            if ((w_late && !tie) || w_at_cap) begin
              // Visitor ahead after a late bottom half, or draw at the cap.
              w_state_nxt = S_GAME_OVER;
              w_end_nxt   = 1'b1;
            end else begin
              w_state_nxt  = S_TOP;
              w_inning_nxt = r_inning + 4'd1;
              w_adv_nxt    = 1'b1;
            end
          end
        end

        S_GAME_OVER: begin
          // Final inning is frozen until a restart.
          w_state_nxt  = S_GAME_OVER;
          w_inning_nxt = r_inning;
        end

        default: begin
          w_state_nxt  = S_TOP;
          w_inning_nxt = c_FIRST;
        end
      endcase
    end
  end

  // Ones digit of the next inning (range 1..15) for the display.
  assign w_ones_nxt = (w_inning_nxt >= c_TEN) ? (w_inning_nxt - c_TEN) : w_inning_nxt;
  assign w_seg_nxt  = seg_encode(w_ones_nxt);

  // State register with every output registered from its next value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_TOP;
      r_inning   <= c_FIRST;
      top_led    <= 1'b1;
      bottom_led <= 1'b0;
      game_over  <= 1'b0;
      inning     <= c_FIRST;
      inning_seg <= 7'b0110000;
      tens_led   <= 1'b0;
      adv_pulse  <= 1'b0;
      end_pulse  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inning   <= w_inning_nxt;
      top_led    <= (w_state_nxt == S_TOP);
      bottom_led <= (w_state_nxt == S_BOTTOM);
      game_over  <= (w_state_nxt == S_GAME_OVER);
      inning     <= w_inning_nxt;
      inning_seg <= w_seg_nxt;
      tens_led   <= (w_inning_nxt >= c_TEN);
      adv_pulse  <= w_adv_nxt;
      end_pulse  <= w_end_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inning_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inning_counter
//  Description : Self-checking bench for inning_counter, comparing every
//                cycle against a game-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inning_counter;

  localparam int LAST = 9;
  localparam int MAXI = 12;

  logic       clk;
  logic       reset_n;
  logic       change_pulse;
  logic       home_lead;
  logic       tie;
  logic       new_game;
  logic       top_led;
  logic       bottom_led;
  logic       game_over;
  logic [3:0] inning;
  logic [6:0] inning_seg;
  logic       tens_led;
  logic       adv_pulse;
  logic       end_pulse;

  inning_counter #(
    .LAST_INNING(LAST),
    .MAX_INNING (MAXI)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .change_pulse(change_pulse),
    .home_lead   (home_lead),
    .tie         (tie),
    .new_game    (new_game),
    .top_led     (top_led),
    .bottom_led  (bottom_led),
    .game_over   (game_over),
    .inning      (inning),
    .inning_seg  (inning_seg),
    .tens_led    (tens_led),
    .adv_pulse   (adv_pulse),
    .end_pulse   (end_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed outputs packed as {top,bottom,over,inning,seg,tens,adv,end}.
  logic [16:0] outs;
  assign outs = {top_led, bottom_led, game_over, inning, inning_seg, tens_led, adv_pulse, end_pulse};

  localparam logic [16:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 4'd1, 7'b0110000, 1'b0, 1'b0, 1'b0};

  // Digit patterns of a seven-segment display, a..g.
  logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: the game as a scorekeeper sees it.
  int m_inning;
  bit m_bottom;
  bit m_over;
  bit m_adv;
  bit m_end;

  function automatic void model_reset();
    m_inning = 1; m_bottom = 0; m_over = 0; m_adv = 0; m_end = 0;
  endfunction

  function automatic void finish_game();
    m_over = 1; m_end = 1;
  endfunction

  // One clock edge of the game rules applied to the current inputs.
  function automatic void model_step();
    m_adv = 0; m_end = 0;
    if (new_game) begin
      m_inning = 1; m_bottom = 0; m_over = 0;
    end else if (!m_over) begin
      if (m_bottom && m_inning >= LAST && home_lead) begin
        finish_game();                              // walk-off
      end else if (change_pulse) begin
        if (!m_bottom) begin
          if (m_inning >= LAST && home_lead) finish_game();
          else begin m_bottom = 1; m_adv = 1; end
        end else begin
          if (m_inning >= LAST && !tie) finish_game();
          else if (m_inning == MAXI) finish_game(); // draw
          else begin m_inning++; m_bottom = 0; m_adv = 1; end
        end
      end
    end
  endfunction

  function automatic logic [16:0] exp_outs();
    logic t, b;
    t = !m_over && !m_bottom;
    b = !m_over && m_bottom;
    return {t, b, m_over, 4'(m_inning), seg_tab[m_inning % 10], (m_inning >= 10), m_adv, m_end};
  endfunction

  // Advance one clock, step the model, settle past the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL new_game_start: got %b required %b", outs, RESET_VEC);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_initial: got %b required %b", outs, RESET_VEC);
    end
    change_pulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++;
        $display("FAIL reset_play%0d: got %b required %b", i, outs, exp_outs());
      end
    end
    change_pulse = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_async: got %b required %b", outs, RESET_VEC);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_release: got %b required %b", outs, RESET_VEC);
    end
  endtask

  task automatic test_regulation();
    int advs;
    int ends;
    advs = 0; ends = 0;
    start_game();
    home_lead = 1'b0; tie = 1'b0;
    change_pulse = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++;
        $display("FAIL regulation_step%0d: got %b required %b", i, outs, exp_outs());
      end
      advs += int'(adv_pulse);
      ends += int'(end_pulse);
      if (i == 15) begin
        n_checks++;
        if (advs != 16 || {top_led, inning} !== {1'b1, 4'd9}) begin
          n_fail++;
          $display("FAIL regulation_top9: got adv=%0d top=%b inning=%0d required adv=16 top=1 inning=9",
                   advs, top_led, inning);
        end
      end
      if (i == 16) begin
        n_checks++;
        if ({bottom_led, inning} !== {1'b1, 4'd9}) begin
          n_fail++;
          $display("FAIL regulation_bottom9: got bottom=%b inning=%0d required bottom=1 inning=9",
                   bottom_led, inning);
        end
      end
    end
    change_pulse = 1'b0;
    tick();
    ends += int'(end_pulse);
    n_checks++;
    if ({game_over, top_led, bottom_led, inning} !== {3'b100, 4'd9} || ends != 1) begin
      n_fail++;
      $display("FAIL regulation_end: got over=%b top=%b bot=%b inning=%0d ends=%0d required 1 0 0 9 ends=1",
               game_over, top_led, bottom_led, inning, ends);
    end
  endtask

  task automatic test_bottom_skipped();
    start_game();
    home_lead = 1'b0; tie = 1'b1;
    change_pulse = 1'b1;
    repeat (16) tick();
    change_pulse = 1'b0;
    home_lead = 1'b1;
    tick();
    change_pulse = 1'b1;
    tick();
    change_pulse = 1'b0;
    n_checks++;
    if ({game_over, bottom_led, end_pulse, inning} !== {3'b101, 4'd9}) begin
      n_fail++;
      $display("FAIL skip_bottom: got over=%b bot=%b end=%b inning=%0d required 1 0 1 9",
               game_over, bottom_led, end_pulse, inning);
    end
    change_pulse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (outs !== exp_outs() || inning !== 4'd9) begin
        n_fail++;
        $display("FAIL skip_hold%0d: got %b required %b", i, outs, exp_outs());
      end
    end
    change_pulse = 1'b0;
    home_lead = 1'b0;
  endtask

  task automatic test_extras_draw();
    start_game();
    home_lead = 1'b0; tie = 1'b1;
    change_pulse = 1'b1;
    for (int i = 0; i < 23; i++) begin
      tick();
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++;
        $display("FAIL extras_step%0d: got %b required %b", i, outs, exp_outs());
      end
    end
    n_checks++;
    if ({bottom_led, tens_led, inning_seg, inning} !== {2'b11, 7'b1101101, 4'd12}) begin
      n_fail++;
      $display("FAIL extras_bottom12: got bot=%b tens=%b seg=%b inning=%0d required 1 1 1101101 12",
               bottom_led, tens_led, inning_seg, inning);
    end
    tick();
    change_pulse = 1'b0;
    n_checks++;
    if ({game_over, end_pulse, inning} !== {2'b11, 4'd12}) begin
      n_fail++;
      $display("FAIL extras_draw: got over=%b end=%b inning=%0d required 1 1 12",
               game_over, end_pulse, inning);
    end
  endtask

  task automatic test_walkoff();
    int ends;
    ends = 0;
    start_game();
    home_lead = 1'b0; tie = 1'b1;
    change_pulse = 1'b1;
    repeat (19) tick();
    change_pulse = 1'b0;
    n_checks++;
    if ({bottom_led, inning} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL walkoff_setup: got bot=%b inning=%0d required 1 10", bottom_led, inning);
    end
    home_lead = 1'b1;
    tick();
    home_lead = 1'b0;
    ends += int'(end_pulse);
    n_checks++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL walkoff_over: got %b required 1", game_over);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ends += int'(end_pulse);
    end
    n_checks++;
    if (ends != 1 || outs !== exp_outs()) begin
      n_fail++;
      $display("FAIL walkoff_end_once: got ends=%0d outs=%b required ends=1 outs=%b", ends, outs, exp_outs());
    end
  endtask

  task automatic test_back_to_back_restart();
    start_game();
    home_lead = 1'b0; tie = 1'b0;
    change_pulse = 1'b1;
    repeat (9) tick();
    n_checks++;
    if ({bottom_led, inning} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL restart_setup: got bot=%b inning=%0d required 1 5", bottom_led, inning);
    end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL restart_priority: got %b required %b", outs, RESET_VEC);
    end
    repeat (18) tick();
    change_pulse = 1'b0;
    tick();
    n_checks++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_reach_over: got %b required 1", game_over);
    end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    n_checks++;
    if (outs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL restart_from_over: got %b required %b", outs, RESET_VEC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      change_pulse = ($urandom_range(0, 2) != 0);
      home_lead    = ($urandom_range(0, 9) == 0);
      tie          = ($urandom_range(0, 2) != 0);
      new_game     = ($urandom_range(0, 59) == 0);
      tick();
      n_checks++;
      if (outs !== exp_outs()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %b required %b", i, outs, exp_outs());
      end
    end
    change_pulse = 1'b0; home_lead = 1'b0; tie = 1'b0; new_game = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    change_pulse = 1'b0;
    home_lead = 1'b0;
    tie = 1'b0;
    new_game = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    test_reset();
    test_regulation();
    test_bottom_skipped();
    test_extras_draw();
    test_walkoff();
    test_back_to_back_restart();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inning_counter.md
# inning_counter

Half-inning / inning tracker that consumes the one-cycle `change_pulse` emitted by the out-count LED block after three outs. It advances top/bottom of each inning, and applies the end-of-game rules: home team leading after the top of the last inning, walk-off, decisive bottom half, or draw at the extra-inning cap. It drives the top/bottom LEDs, a one-digit seven-segment inning display plus tens LED, and game-over status for the scoreboard.

## Interface
- `LAST_INNING`, 9, regulation innings; legal range 1..`MAX_INNING`
- `MAX_INNING`, 12, extra-inning cap where the game ends as a draw; legal range ≤ 15
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `change_pulse`  in  1  one-cycle half-inning-over pulse, synchronous to `clk`
- `home_lead`  in  1  level: home score > visitor score
- `tie`  in  1  level: scores equal; ignored when `home_lead`=1
- `new_game`  in  1  one-cycle synchronous restart pulse
- `top_led`  out  1  top half in progress
- `bottom_led`  out  1  bottom half in progress
- `game_over`  out  1  game finished, level
- `inning`  out  4  current inning, binary, 1..`MAX_INNING`
- `inning_seg`  out  7  ones digit of `inning`, active-high, bit6..bit0 = a..g
- `tens_led`  out  1  `inning` ≥ 10
- `adv_pulse`  out  1  one cycle per half-inning advance
- `end_pulse`  out  1  one cycle on entering GAME_OVER

## Operation
- **States:** TOP, BOTTOM, GAME_OVER, plus a 4-bit inning register.
- **Reset values:** state TOP, `inning`=1, `top_led`=1, `bottom_led`=0, `game_over`=0, `inning_seg`=0110000, `tens_led`=0, `adv_pulse`=0, `end_pulse`=0.
- **TOP on `change_pulse`:**
  - `inning` ≥ `LAST_INNING` and `home_lead`=1 → GAME_OVER. The bottom half is skipped.
  - Otherwise → BOTTOM, with `adv_pulse`.
- **BOTTOM on `change_pulse`:**
  - `inning` ≥ `LAST_INNING` and (`home_lead` or !`tie`) → GAME_OVER.
  - Else `inning`=`MAX_INNING` → GAME_OVER (draw).
  - Else `inning`+1 and → TOP, with `adv_pulse`.
- **Walk-off:** in BOTTOM with `inning` ≥ `LAST_INNING`, `home_lead`=1 sampled at any edge → GAME_OVER, independent of `change_pulse`.
- **GAME_OVER:**
  - `change_pulse`, `home_lead` and `tie` are ignored.
  - `inning` holds the final value.
  - `top_led`=`bottom_led`=0 and `game_over`=1.
- **`new_game`:** in any state, forces TOP with `inning`=1 at the next edge. It has priority over `change_pulse` and walk-off. It produces neither `adv_pulse` nor `end_pulse`.
- **Inning register:** never exceeds `MAX_INNING` and never wraps.
- **Seven-segment encoding** of `inning` mod 10:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- **Unused state encodings:** recover to TOP / `inning` 1 on the next edge.

## Timing
- All outputs are registered; no combinational path from input to output.
- A `change_pulse` sampled high at edge N gives new state, LEDs, `inning` and `inning_seg` valid after edge N.
- `adv_pulse` / `end_pulse` are high for exactly the cycle following edge N.
- Back-to-back `change_pulse` on consecutive cycles advances once per cycle. No pulse is lost.
- `home_lead` / `tie` are sampled on the same edge as `change_pulse`. Score updates must settle before the out pulse.
- An asynchronous `reset_n` assertion mid-game immediately forces reset values. Release is synchronous to `clk` at the board level.

## Test plan
- **Reset:** assert `reset_n`=0 mid-game → immediately `top_led`=1, `inning`=1, `inning_seg`=0110000, `game_over`=0.
- **Regulation visitor win:** with `home_lead`=0, `tie`=0, send 16 `change_pulse` → TOP of 9, `adv_pulse` counted 16. The 17th pulse → BOTTOM 9. The 18th pulse → `game_over`=1, `inning`=9, single `end_pulse`, both half LEDs off.
- **Bottom skipped:** at TOP 9 with `home_lead`=1, send `change_pulse` → GAME_OVER with no BOTTOM; further pulses leave `inning`=9.
- **Extras to draw:** `tie`=1 throughout → advances to BOTTOM 12 with `tens_led`=1 and `inning_seg`=1101101. The next pulse → GAME_OVER, `inning`=12.
- **Walk-off:** at BOTTOM 10 with `tie`=1, raise `home_lead` for one cycle without `change_pulse` → `game_over`=1 one edge later, `end_pulse` once.
- **Restart priority:** at BOTTOM 5, `new_game` and `change_pulse` asserted together → TOP 1, no `adv_pulse`. Then `new_game` from GAME_OVER → TOP 1, `game_over`=0.
